ub_skew_bram: RTL and testbench

Parametrised unified buffer for the systolic-array datapath: a LANES-wide byte-lane-maskable simple-dual-port RAM with a burst-read engine that streams consecutive rows out with a per-lane diagonal skew, so lane i arrives i cycles after lane 0. It replaces single-word BRAM reads with a self-sequenced burst that feeds the array edge directly and zero-pads the wavefront.

---
 rtl/ub_skew_bram.sv | 213 +++++++++++++++++++++
 tb/tb_ub_skew_bram.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ub_skew_bram.sv
// Unified buffer: byte-lane-maskable SDP RAM plus a burst engine that streams rows with a per-lane diagonal skew.
// Latency: rd_start accepted at edge T -> lane i valid from T+2+i, rd_done at T+len+LANES (skew) or T+len+1.
// Backpressure: none; rd_start is ignored while rd_busy=1 or rd_len=0. Optional skew enabled by macro UB_SKEW_EN.
module ub_skew_bram #(
  parameter  int DATA_W = 8,
  parameter  int LANES  = 16,
  parameter  int DEPTH  = 256,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [LANES-1:0]        wr_mask,
  input  logic [LANES*DATA_W-1:0] wr_data,
  input  logic                    rd_start,
  input  logic [ADDR_W-1:0]       rd_base,
  input  logic [ADDR_W:0]         rd_len,
  output logic                    rd_busy,
  output logic [LANES-1:0]        out_valid,
  output logic [LANES*DATA_W-1:0] out_data,
  output logic                    rd_done
);

  localparam int ROW_W = LANES * DATA_W;
  localparam int DRN_W = $clog2(LANES) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DRN_W-1:0]  drn_q, drn_d;
  logic              rd_issue;
  logic              rd_last;
  logic              done;

  logic [ROW_W-1:0]  mem [DEPTH];
  logic [ROW_W-1:0]  ram_dat_q, ram_dat_d;
  logic              ram_vld_q, ram_vld_d;
  logic              ram_last_q, ram_last_d;

  // Busy covers the FSM plus the final beat of the last lane, which
  // lands one cycle after the FSM has already returned to IDLE.
  assign rd_busy = (state_q != IDLE) || done;
  assign rd_done = done;

  // Burst sequencer: next state, address walk and remaining-row count.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    cnt_d    = cnt_q;
    drn_d    = drn_q;
    rd_issue = 1'b0;
    rd_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_start && (rd_len != '0) && !done) begin
          state_d = READ;
          addr_d  = rd_base;
          cnt_d   = rd_len;
        end
      end
      READ: begin
        rd_issue = 1'b1;
        addr_d   = addr_q + 1'b1;  // DEPTH is a power of two, so this wraps
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == (ADDR_W+1)'(1)) begin
          rd_last = 1'b1;
`ifdef UB_SKEW_EN
          if (LANES > 1) begin
            state_d = DRAIN;
            drn_d   = DRN_W'(LANES - 1);
          end else begin
            state_d = IDLE;
          end
`else
          state_d = IDLE;
`endif
        end
      end
      DRAIN: begin
        drn_d = drn_q - 1'b1;
        if (drn_q == DRN_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM read port: old contents are seen on a same-row write (read-first).
  always_comb begin
    ram_dat_d  = rd_issue ? mem[addr_q] : '0;
    ram_vld_d  = rd_issue;
    ram_last_d = rd_last;
  end

  // Lane-masked write port; storage is not reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (wr_mask[i]) begin
          mem[wr_addr][i*DATA_W +: DATA_W] <= wr_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Sequencer state and RAM output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      cnt_q      <= '0;
      drn_q      <= '0;
      ram_dat_q  <= '0;
      ram_vld_q  <= 1'b0;
      ram_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      drn_q      <= drn_d;
      ram_dat_q  <= ram_dat_d;
      ram_vld_q  <= ram_vld_d;
      ram_last_q <= ram_last_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [DATA_W-1:0] lane_dat;
    logic              lane_vld;
`ifdef UB_SKEW_EN
    if (i == 0) begin : g_tap0
      assign lane_dat = ram_dat_q[0 +: DATA_W];
      assign lane_vld = ram_vld_q;
    end else begin : g_dly
      logic [DATA_W-1:0] dly_dat_q [i];
      logic [DATA_W-1:0] dly_dat_d [i];
      logic [i-1:0]      dly_vld_q, dly_vld_d;

      // Lane i rides i stages behind the RAM register; valid travels alongside.
      always_comb begin
        dly_dat_d[0] = ram_dat_q[i*DATA_W +: DATA_W];
        dly_vld_d    = '0;
        dly_vld_d[0] = ram_vld_q;
        for (int s = 1; s < i; s++) begin
          dly_dat_d[s] = dly_dat_q[s-1];
          dly_vld_d[s] = dly_vld_q[s-1];
        end
      end

      // Skew stage registers for lane i.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int s = 0; s < i; s++) begin
            dly_dat_q[s] <= '0;
          end
          dly_vld_q <= '0;
        end else begin
          dly_dat_q <= dly_dat_d;
          dly_vld_q <= dly_vld_d;
        end
      end

      assign lane_dat = dly_dat_q[i-1];
      assign lane_vld = dly_vld_q[i-1];
    end
`else
    assign lane_dat = ram_dat_q[i*DATA_W +: DATA_W];
    assign lane_vld = ram_vld_q;
`endif
    // Zero-pad the wavefront: idle lanes drive 0 rather than stale data.
    assign out_valid[i]                     = lane_vld;
    assign out_data[i*DATA_W +: DATA_W]     = lane_vld ? lane_dat : '0;
  end

`ifdef UB_SKEW_EN
  if (LANES > 1) begin : g_done_dly
    logic [LANES-2:0] last_sr_q, last_sr_d;

    // The last-row marker follows the deepest lane so rd_done hits its final beat.
    always_comb begin
      last_sr_d    = '0;
      last_sr_d[0] = ram_last_q;
      for (int s = 1; s < LANES - 1; s++) begin
        last_sr_d[s] = last_sr_q[s-1];
      end
    end

    // Last-row marker delay line.
    always_ff @(posedge clk) begin
      if (reset) begin
        last_sr_q <= '0;
      end else begin
        last_sr_q <= last_sr_d;
      end
    end

    assign done = last_sr_q[LANES-2];
  end else begin : g_done_now
    assign done = ram_last_q;
  end
`else
  assign done = ram_last_q;
`endif

endmodule

// File: tb/tb_ub_skew_bram.sv
`timescale 1ns/1ps
// Bench for ub_skew_bram: table of masked writes read back by single-row bursts,
// then hand sequences for wrap, busy/zero-length rejection, collision, reset and full depth.
// Expected beats are queued per lane at rd_start time and retired by a negedge monitor.
module tb_ub_skew_bram;
  localparam int DATA_W = 8;
  localparam int LANES  = 16;
  localparam int DEPTH  = 256;
  localparam int ADDR_W = 8;
  localparam int ROW_W  = LANES * DATA_W;
`ifdef UB_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              wr_en = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [LANES-1:0]  wr_mask = '0;
  logic [ROW_W-1:0]  wr_data = '0;
  logic              rd_start = 1'b0;
  logic [ADDR_W-1:0] rd_base = '0;
  logic [ADDR_W:0]   rd_len = '0;
  logic              rd_busy;
  logic [LANES-1:0]  out_valid;
  logic [ROW_W-1:0]  out_data;
  logic              rd_done;

  ub_skew_bram #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_mask(wr_mask), .wr_data(wr_data),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len),
    .rd_busy(rd_busy), .out_valid(out_valid), .out_data(out_data), .rd_done(rd_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         cyc;
    logic [7:0] dat;
  } beat_t;

  typedef struct {
    int               addr;
    logic [15:0]      mask;
    logic [ROW_W-1:0] data;
    logic [ROW_W-1:0] exp;
  } vec_t;

  beat_t            lane_q [LANES][$];
  int               done_q [$];
  int               busy_lo = 1;
  int               busy_hi = 0;
  logic [ROW_W-1:0] shadow [DEPTH];
  bit               mon_en = 1'b0;
  int               n_checks = 0;
  int               n_pass = 0;

  task automatic check(input string name, input logic [ROW_W-1:0] got, input logic [ROW_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_row(input int addr, input logic [15:0] mask, input logic [ROW_W-1:0] data);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_mask = mask;
    wr_data = data;
    step(1);
    wr_en   = 1'b0;
    wr_mask = '0;
    for (int i = 0; i < LANES; i++)
      if (mask[i]) shadow[addr][i*DATA_W +: DATA_W] = data[i*DATA_W +: DATA_W];
  endtask

  // Drive rd_start for one cycle; if the request should be accepted, queue its beats.
  task automatic do_burst(input int base, input int len, input bit use_tab, input logic [ROW_W-1:0] tab_row);
    int               c;
    int               e;
    int               dn;
    bit               acc;
    logic [ROW_W-1:0] row;
    beat_t            b;
    c        = cyc;
    acc      = (len != 0) && !(c >= busy_lo && c <= busy_hi);
    rd_start = 1'b1;
    rd_base  = ADDR_W'(base);
    rd_len   = (ADDR_W+1)'(len);
    if (acc) begin
      e = c + 1;
      for (int k = 0; k < len; k++) begin
        row = use_tab ? tab_row : shadow[(base + k) % DEPTH];
        for (int i = 0; i < LANES; i++) begin
          b.cyc = e + 1 + i * SKEW + k;
          b.dat = row[i*DATA_W +: DATA_W];
          lane_q[i].push_back(b);
        end
      end
      dn = e + len + (LANES - 1) * SKEW;
      done_q.push_back(dn);
      busy_lo = e;
      busy_hi = dn;
    end
    step(1);
    rd_start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = busy_hi - cyc + 2;
    if (n < 1) n = 1;
    step(n);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #6;
    for (int i = 0; i < LANES; i++) lane_q[i].delete();
    done_q.delete();
    busy_lo = 1;
    busy_hi = 0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy", rd_busy, 0);
    check("abort_valid", out_valid, 0);
    check("abort_done", rd_done, 0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: retire queued beats and rd_done, enforce zero padding and the busy window.
  always @(negedge clk) begin
    beat_t b;
    int    d;
    if (mon_en) begin
      for (int i = 0; i < LANES; i++) begin
        if (out_valid[i]) begin
          if (lane_q[i].size() != 0 && lane_q[i][0].cyc <= cyc) begin
            b = lane_q[i].pop_front();
            check($sformatf("beat_time lane%0d", i), cyc, b.cyc);
            check($sformatf("beat_data lane%0d", i), out_data[i*DATA_W +: DATA_W], b.dat);
          end else begin
            check($sformatf("beat_unexpected lane%0d", i), 1, 0);
          end
        end else begin
          check($sformatf("pad_zero lane%0d", i), out_data[i*DATA_W +: DATA_W], 0);
          if (lane_q[i].size() != 0 && lane_q[i][0].cyc <= cyc) begin
            b = lane_q[i].pop_front();
            check($sformatf("beat_missing lane%0d", i), 0, 1);
          end
        end
      end
      check("rd_busy", rd_busy, (cyc >= busy_lo && cyc <= busy_hi));
      if (done_q.size() != 0 && done_q[0] <= cyc) begin
        d = done_q.pop_front();
        check("rd_done", rd_done, 1);
      end else begin
        check("rd_done_spurious", rd_done, 0);
      end
    end
  end

  initial begin
    vec_t             tab [6];
    logic [ROW_W-1:0] row;

    tab[0] = '{addr: 5, mask: 16'hFFFF, data: {16{8'hAA}}, exp: {16{8'hAA}}};
    tab[1] = '{addr: 5, mask: 16'h0001, data: {16{8'h55}}, exp: {{15{8'hAA}}, 8'h55}};
    tab[2] = '{addr: 9, mask: 16'hFFFF, data: 128'h0F0E0D0C0B0A09080706050403020100,
               exp: 128'h0F0E0D0C0B0A09080706050403020100};
    tab[3] = '{addr: 9, mask: 16'h8000, data: {16{8'hFF}}, exp: 128'hFF0E0D0C0B0A09080706050403020100};
    tab[4] = '{addr: 9, mask: 16'h00F0, data: {16{8'h33}}, exp: 128'hFF0E0D0C0B0A09083333333303020100};
    tab[5] = '{addr: 9, mask: 16'h0000, data: {16{8'h77}}, exp: 128'hFF0E0D0C0B0A09083333333303020100};

    for (int r = 0; r < DEPTH; r++) shadow[r] = '0;

    // Reset state
    step(3);
    @(negedge clk);
    check("reset_busy", rd_busy, 0);
    check("reset_valid", out_valid, 0);
    check("reset_data", out_data, 0);
    check("reset_done", rd_done, 0);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_en = 1'b1;

    // Known contents everywhere: row r lane i = 3r + i
    for (int r = 0; r < DEPTH; r++) begin
      for (int i = 0; i < LANES; i++) row[i*DATA_W +: DATA_W] = 8'(r * 3 + i);
      wr_row(r, 16'hFFFF, row);
    end

    // Masked writes, each read back by a len=1 burst against the table row
    for (int t = 0; t < 6; t++) begin
      wr_row(tab[t].addr, tab[t].mask, tab[t].data);
      do_burst(tab[t].addr, 1, 1'b1, tab[t].exp);
      wait_idle();
    end

    // Wrap-around 254,255,0,1
    wr_row(254, 16'hFFFF, {16{8'h01}});
    wr_row(255, 16'hFFFF, {16{8'h02}});
    wr_row(0,   16'hFFFF, {16{8'h03}});
    wr_row(1,   16'hFFFF, {16{8'h04}});
    do_burst(254, 4, 1'b0, '0);
    // Busy rejection mid-burst and in the rd_done cycle, then back-to-back accept
    step(2);
    do_burst(100, 3, 1'b0, '0);
    while (cyc < busy_hi) step(1);
    do_burst(120, 2, 1'b0, '0);
    do_burst(30, 2, 1'b0, '0);
    wait_idle();
    // Zero length in IDLE is ignored
    do_burst(40, 0, 1'b0, '0);
    @(negedge clk);
    check("zero_len_busy", rd_busy, 0);
    @(posedge clk);
    #1;
    step(3);

    // Read/write collision on row 7
    wr_row(7, 16'hFFFF, {16{8'h11}});
    do_burst(7, 1, 1'b0, '0);
    wr_row(7, 16'hFFFF, {16{8'h22}});
    wait_idle();
    do_burst(7, 1, 1'b0, '0);
    wait_idle();

    // Reset mid-burst, then re-read the same rows
    do_burst(5, 8, 1'b0, '0);
    step(5);
    do_reset();
    step(3);
    do_burst(5, 8, 1'b0, '0);
    wait_idle();

    // Full depth from base 0
    do_burst(0, DEPTH, 1'b0, '0);
    wait_idle();
    step(2);

    mon_en = 1'b0;
    for (int i = 0; i < LANES; i++) check($sformatf("leftover lane%0d", i), lane_q[i].size(), 0);
    check("leftover rd_done", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
